fetch_npc: RTL and testbench
============================

// Module: fetch_npc
// PURPOSE
//  IF stage plus IF/ID pipeline register of the 5-stage MIPS core. Owns the PC,
//  presents it to IM, latches the fetched word into D, and decodes the D-stage
//  control-flow opcode. It consumes the branch decision (judge) produced by the
//  D-stage comparator and redirects fetch. One branch delay slot; no flush.
// PARAMETERS
//  RESET_PC  32'h0000_3000  PC value loaded on reset
//  CNT_W     16             width of branch statistic counters
// PORTS
//  clk         in   1      rising-edge clock
//  reset       in   1      synchronous, active-high reset
//  stall       in   1      hazard unit: hold PC and IF/ID this cycle
//  instr_f     in   32     instruction word read from IM at pc_f
//  judge       in   1      comparator result for branch in D (1 = taken)
//  rs_d        in   32     forwarded GPR[rs] for the instruction in D (jr/jalr)
//  pc_f        out  32     current fetch PC to IM
//  ir_d        out  32     IF/ID instruction register
//  pc_d        out  32     PC of instruction in D
//  pc8_d       out  32     pc_d + 8 (link value for jal/jalr)
//  br_cnt      out  CNT_W  branches resolved in D (beq/bne/bgez)
//  taken_cnt   out  CNT_W  of those, taken
//  misalign    out  1      sticky: a redirect target had [1:0] != 0
// BEHAVIOUR
//  Reset (sync, highest priority): pc_f=RESET_PC; ir_d=0 (nop); pc_d=RESET_PC;
//   br_cnt=0; taken_cnt=0; misalign=0. Reset mid-stall/mid-branch discards all.
//  D-stage decode of ir_d (op=[31:26], rt=[20:16], funct=[5:0]):
//   BR : op 000100 beq | op 000101 bne | op 000001 with rt[0]=1 (bgez)
//   J  : op 000010 j | op 000011 jal
//   JR : op 000000 with funct 001000 jr | 001001 jalr
//  Targets (32-bit, wrap modulo 2^32, no overflow detect):
//   BR: pc_d + 4 + (sign_ext(ir_d[15:0]) << 2)
//   J : {pc_d[31:28], ir_d[25:0], 2'b00}   (region of pc_d, not of delay slot)
//   JR: rs_d
//  next_pc priority: stall -> pc_f held; else BR & judge -> BR target;
//   else J -> J target; else JR -> rs_d; else pc_f + 4.
//  Target with [1:0]!=0: loaded as {target[31:2],2'b00}, misalign set (stays 1
//   until reset). Sequential pc_f+4 never sets misalign.
//  IF/ID update each clk when !stall: ir_d<=instr_f; pc_d<=pc_f. pc8_d is
//   combinational pc_d+8. Delay slot = instr at pc_d+4, already in F during
//   redirect; it always enters D next cycle (never squashed).
//  Stall: pc_f, ir_d, pc_d, counters all hold; the branch stays in D and is
//   resolved (redirect + count) in the first non-stalled cycle only; judge is
//   ignored while stall=1. A branch is counted exactly once.
//  Counters: br_cnt += 1 on each non-stalled cycle with BR in D; taken_cnt +=1
//   when additionally judge=1. Both saturate at 2^CW-1 (no wrap).
//  Latency: redirect visible on pc_f one clk after the branch's D cycle.
//  All outputs registered except pc8_d.
// TESTING
//  1 reset, 4 clk no stall, IM returns nops -> pc_f 3000,3004,3008,300C,3010; ir_d=0.
//  2 beq at 0x3000 imm=0x0003, judge=1 -> pc_f seq 3000,3004,3010; delay slot 3004
//    reaches D; br_cnt=1, taken_cnt=1. Same with judge=0 -> 3008; taken_cnt=0.
//  3 bne in D with stall=1 for 2 clk, judge=1 throughout -> pc_f/ir_d held 2 clk,
//    redirect on 3rd edge, br_cnt increments by exactly 1.
//  4 jal at 0x3FFC, imm26=0x0000C00 -> pc8_d=0x4004, pc_f goes 4000 then 0x3000;
//    jr with rs_d=0x0000_3006 -> pc_f=0x3004, misalign=1 and stays 1.
//  5 bgez imm=0xFFFF at 0x3008 judge=1 -> target 0x3008; bgez-shaped op 000001
//    with rt[0]=0 -> not BR, no count, sequential fetch.
//  6 force br_cnt to 2^CNT_W-1 (CNT_W=4 build), taken branch -> both stay 15;
//    assert reset during stalled branch -> next clk all reset values, no redirect.

Source files
------------

// File: rtl/fetch_npc.sv
// fetch_npc: IF stage and IF/ID pipeline register of the 5-stage MIPS core.
// It owns the fetch PC and latches the fetched word and its PC into D. It
// decodes the control-flow instruction in D and redirects fetch, using the
// branch decision from the D-stage comparator. There is one architectural
// delay slot and no flush. Redirect targets are word-aligned on load. A sticky
// flag records any redirect target whose low two bits were not zero.
module fetch_npc #(
    parameter logic [31:0] RESET_PC = 32'h0000_3000,
    parameter int unsigned CNT_W    = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             stall,
    input  logic [31:0]      instr_f,
    input  logic             judge,
    input  logic [31:0]      rs_d,
    output logic [31:0]      pc_f,
    output logic [31:0]      ir_d,
    output logic [31:0]      pc_d,
    output logic [31:0]      pc8_d,
    output logic [CNT_W-1:0] br_cnt,
    output logic [CNT_W-1:0] taken_cnt,
    output logic             misalign
);

    localparam logic [5:0] OP_SPECIAL = 6'b000000;
    localparam logic [5:0] OP_REGIMM  = 6'b000001;
    localparam logic [5:0] OP_J       = 6'b000010;
    localparam logic [5:0] OP_JAL     = 6'b000011;
    localparam logic [5:0] OP_BEQ     = 6'b000100;
    localparam logic [5:0] OP_BNE     = 6'b000101;
    localparam logic [5:0] FN_JR      = 6'b001000;
    localparam logic [5:0] FN_JALR    = 6'b001001;
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [31:0]      r_pc_f;
    logic [31:0]      r_ir_d;
    logic [31:0]      r_pc_d;
    logic [CNT_W-1:0] r_br_cnt;
    logic [CNT_W-1:0] r_taken_cnt;
    logic             r_misalign;

    logic [5:0]  w_op;
    logic [5:0]  w_funct;
    logic        w_is_br;
    logic        w_is_j;
    logic        w_is_jr;
    logic [31:0] w_br_tgt;
    logic [31:0] w_j_tgt;
    logic        w_redirect;
    logic [31:0] w_tgt;
    logic [31:0] w_next_pc;
    logic        w_br_fire;
    logic        w_tgt_misaligned;

    assign w_op    = r_ir_d[31:26];
    assign w_funct = r_ir_d[5:0];

    // bgez shares the REGIMM opcode with bltz; rt[0] tells them apart
    assign w_is_br = (w_op == OP_BEQ) || (w_op == OP_BNE) ||
                     ((w_op == OP_REGIMM) && r_ir_d[16]);
    assign w_is_j  = (w_op == OP_J) || (w_op == OP_JAL);
    assign w_is_jr = (w_op == OP_SPECIAL) &&
                     ((w_funct == FN_JR) || (w_funct == FN_JALR));

    // Branch offset is relative to the delay slot. The jump region comes from
    // the jump's own PC.
    assign w_br_tgt = r_pc_d + 32'd4 + {{14{r_ir_d[15]}}, r_ir_d[15:0], 2'b00};
    assign w_j_tgt  = {r_pc_d[31:28], r_ir_d[25:0], 2'b00};

    // Pick the redirect source by priority: taken branch, jump, register jump
    always_comb begin
        w_redirect = 1'b0;
        w_tgt      = rs_d;
        if (w_is_br && judge) begin
            w_redirect = 1'b1;
            w_tgt      = w_br_tgt;
        end else if (w_is_j) begin
            w_redirect = 1'b1;
            w_tgt      = w_j_tgt;
        end else if (w_is_jr) begin
            w_redirect = 1'b1;
            w_tgt      = rs_d;
        end
    end

    assign w_tgt_misaligned = w_redirect && (w_tgt[1:0] != 2'b00);
    assign w_br_fire        = !stall && w_is_br;

    // Next fetch address. A stall freezes everything, so a branch held in D
    // is resolved only once, in its first non-stalled cycle.
    always_comb begin
        w_next_pc = r_pc_f + 32'd4;
        if (stall) begin
            w_next_pc = r_pc_f;
        end else if (w_redirect) begin
            w_next_pc = {w_tgt[31:2], 2'b00};
        end
    end

    // PC, IF/ID register, branch statistics and sticky misalign flag
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pc_f      <= RESET_PC;
            r_ir_d      <= 32'd0;
            r_pc_d      <= RESET_PC;
            r_br_cnt    <= '0;
            r_taken_cnt <= '0;
            r_misalign  <= 1'b0;
        end else begin
            r_pc_f <= w_next_pc;
            if (!stall) begin
                r_ir_d <= instr_f;
                r_pc_d <= r_pc_f;
                if (w_tgt_misaligned) begin
                    r_misalign <= 1'b1;
                end
            end
            if (w_br_fire && (r_br_cnt != CNT_MAX)) begin
                r_br_cnt <= r_br_cnt + 1'b1;
            end
            if (w_br_fire && judge && (r_taken_cnt != CNT_MAX)) begin
                r_taken_cnt <= r_taken_cnt + 1'b1;
            end
        end
    end

    assign pc_f      = r_pc_f;
    assign ir_d      = r_ir_d;
    assign pc_d      = r_pc_d;
    assign pc8_d     = r_pc_d + 32'd8;
    assign br_cnt    = r_br_cnt;
    assign taken_cnt = r_taken_cnt;
    assign misalign  = r_misalign;

endmodule

// File: tb/tb_fetch_npc.sv
// Testbench for fetch_npc. Directed vectors are held in a table, applied one
// clock at a time and compared after each edge. A second instance built with
// 4-bit counters covers counter saturation.
module tb_fetch_npc;

    localparam logic [31:0] NOP    = 32'h0000_0000;
    localparam logic [31:0] BEQ3   = 32'h1000_0003;
    localparam logic [31:0] BNE3   = 32'h1400_0003;
    localparam logic [31:0] JAL    = 32'h0C00_0C00;
    localparam logic [31:0] JR     = 32'h0000_0008;
    localparam logic [31:0] BGEZM1 = 32'h0401_FFFF;
    localparam logic [31:0] BLTZM1 = 32'h0400_FFFF;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        stall = 1'b0;
    logic [31:0] instr_f = 32'd0;
    logic        judge = 1'b0;
    logic [31:0] rs_d = 32'd0;

    logic [31:0] pc_f, ir_d, pc_d, pc8_d;
    logic [15:0] br_cnt, taken_cnt;
    logic        misalign;

    logic [31:0] s_pc_f, s_ir_d, s_pc_d, s_pc8_d;
    logic [3:0]  s_br_cnt, s_taken_cnt;
    logic        s_misalign;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    fetch_npc #(.RESET_PC(32'h0000_3000), .CNT_W(16)) dut (
        .clk(clk), .reset(reset), .stall(stall), .instr_f(instr_f),
        .judge(judge), .rs_d(rs_d), .pc_f(pc_f), .ir_d(ir_d), .pc_d(pc_d),
        .pc8_d(pc8_d), .br_cnt(br_cnt), .taken_cnt(taken_cnt),
        .misalign(misalign)
    );

    fetch_npc #(.RESET_PC(32'h0000_3000), .CNT_W(4)) dut4 (
        .clk(clk), .reset(reset), .stall(stall), .instr_f(instr_f),
        .judge(judge), .rs_d(rs_d), .pc_f(s_pc_f), .ir_d(s_ir_d),
        .pc_d(s_pc_d), .pc8_d(s_pc8_d), .br_cnt(s_br_cnt),
        .taken_cnt(s_taken_cnt), .misalign(s_misalign)
    );

    typedef struct {
        logic        rst;
        logic        stl;
        logic [31:0] ins;
        logic        jdg;
        logic [31:0] rs;
        logic [31:0] e_pcf;
        logic [31:0] e_ir;
        logic [31:0] e_pcd;
        logic [15:0] e_br;
        logic [15:0] e_tk;
        logic        e_mis;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic rst, input logic stl, input logic [31:0] ins,
                       input logic jdg, input logic [31:0] rs,
                       input logic [31:0] e_pcf, input logic [31:0] e_ir,
                       input logic [31:0] e_pcd, input logic [15:0] e_br,
                       input logic [15:0] e_tk, input logic e_mis);
        vec_t v;
        v.rst = rst; v.stl = stl; v.ins = ins; v.jdg = jdg; v.rs = rs;
        v.e_pcf = e_pcf; v.e_ir = e_ir; v.e_pcd = e_pcd;
        v.e_br = e_br; v.e_tk = e_tk; v.e_mis = e_mis;
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input int idx,
                       input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s step %0d: got %h expected %h", name, idx, act, exp);
        end
    endtask

    initial begin
        //   rst  stl  instr   jdg  rs_d          pc_f          ir_d    pc_d          br tk mis
        // reset and plain sequential fetch of nops
        add(1, 0, NOP,    0, 32'h0,    32'h3000, NOP,    32'h3000, 0, 0, 0);
        add(0, 0, NOP,    0, 32'h0,    32'h3004, NOP,    32'h3000, 0, 0, 0);
        add(0, 0, NOP,    0, 32'h0,    32'h3008, NOP,    32'h3004, 0, 0, 0);
        add(0, 0, NOP,    0, 32'h0,    32'h300C, NOP,    32'h3008, 0, 0, 0);
        add(0, 0, NOP,    0, 32'h0,    32'h3010, NOP,    32'h300C, 0, 0, 0);
        // beq taken: delay slot 3004 reaches D, fetch goes to 3010
        add(1, 0, NOP,    0, 32'h0,    32'h3000, NOP,    32'h3000, 0, 0, 0);
        add(0, 0, BEQ3,   0, 32'h0,    32'h3004, BEQ3,   32'h3000, 0, 0, 0);
        add(0, 0, NOP,    1, 32'h0,    32'h3010, NOP,    32'h3004, 1, 1, 0);
        add(0, 0, NOP,    1, 32'h0,    32'h3014, NOP,    32'h3010, 1, 1, 0);
        // beq not taken
        add(1, 0, NOP,    0, 32'h0,    32'h3000, NOP,    32'h3000, 0, 0, 0);
        add(0, 0, BEQ3,   0, 32'h0,    32'h3004, BEQ3,   32'h3000, 0, 0, 0);
        add(0, 0, NOP,    0, 32'h0,    32'h3008, NOP,    32'h3004, 1, 0, 0);
        // bne held in D by a two-cycle stall, resolved on the third edge
        add(1, 0, NOP,    0, 32'h0,    32'h3000, NOP,    32'h3000, 0, 0, 0);
        add(0, 0, BNE3,   0, 32'h0,    32'h3004, BNE3,   32'h3000, 0, 0, 0);
        add(0, 1, 32'h11111111, 1, 32'h0, 32'h3004, BNE3, 32'h3000, 0, 0, 0);
        add(0, 1, 32'h22222222, 1, 32'h0, 32'h3004, BNE3, 32'h3000, 0, 0, 0);
        add(0, 0, NOP,    1, 32'h0,    32'h3010, NOP,    32'h3004, 1, 1, 0);
        // jr to 3FFC, jal there back to 3000, then jr to misaligned 3006
        add(1, 0, NOP,    0, 32'h0,    32'h3000, NOP,    32'h3000, 0, 0, 0);
        add(0, 0, JR,     0, 32'h0,    32'h3004, JR,     32'h3000, 0, 0, 0);
        add(0, 0, NOP,    0, 32'h3FFC, 32'h3FFC, NOP,    32'h3004, 0, 0, 0);
        add(0, 0, JAL,    0, 32'h0,    32'h4000, JAL,    32'h3FFC, 0, 0, 0);
        add(0, 0, NOP,    0, 32'h0,    32'h3000, NOP,    32'h4000, 0, 0, 0);
        add(0, 0, JR,     0, 32'h0,    32'h3004, JR,     32'h3000, 0, 0, 0);
        add(0, 0, NOP,    0, 32'h3006, 32'h3004, NOP,    32'h3004, 0, 0, 1);
        add(0, 0, NOP,    0, 32'h0,    32'h3008, NOP,    32'h3004, 0, 0, 1);
        // bgez -1 at 3008 loops to itself; bltz-shaped op is not a branch
        add(0, 0, BGEZM1, 0, 32'h0,    32'h300C, BGEZM1, 32'h3008, 0, 0, 1);
        add(0, 0, NOP,    1, 32'h0,    32'h3008, NOP,    32'h300C, 1, 1, 1);
        add(0, 0, BLTZM1, 0, 32'h0,    32'h300C, BLTZM1, 32'h3008, 1, 1, 1);
        add(0, 0, NOP,    1, 32'h0,    32'h3010, NOP,    32'h300C, 1, 1, 1);
        // reset during a stalled branch discards it
        add(0, 0, BEQ3,   0, 32'h0,    32'h3014, BEQ3,   32'h3010, 1, 1, 1);
        add(0, 1, NOP,    1, 32'h0,    32'h3014, BEQ3,   32'h3010, 1, 1, 1);
        add(1, 1, NOP,    1, 32'h0,    32'h3000, NOP,    32'h3000, 0, 0, 0);
        add(0, 0, NOP,    1, 32'h0,    32'h3004, NOP,    32'h3000, 0, 0, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            reset   = vecs[i].rst;
            stall   = vecs[i].stl;
            instr_f = vecs[i].ins;
            judge   = vecs[i].jdg;
            rs_d    = vecs[i].rs;
            @(posedge clk);
            #1;
            $display("step %0d rst=%b stall=%b instr=%h judge=%b -> pc_f=%h ir_d=%h pc_d=%h pc8_d=%h br=%0d tk=%0d mis=%b",
                     i, reset, stall, instr_f, judge, pc_f, ir_d, pc_d, pc8_d,
                     br_cnt, taken_cnt, misalign);
            chk("pc_f",      i, pc_f,  vecs[i].e_pcf);
            chk("ir_d",      i, ir_d,  vecs[i].e_ir);
            chk("pc_d",      i, pc_d,  vecs[i].e_pcd);
            chk("pc8_d",     i, pc8_d, vecs[i].e_pcd + 32'd8);
            chk("br_cnt",    i, {16'd0, br_cnt},    {16'd0, vecs[i].e_br});
            chk("taken_cnt", i, {16'd0, taken_cnt}, {16'd0, vecs[i].e_tk});
            chk("misalign",  i, {31'd0, misalign},  {31'd0, vecs[i].e_mis});
        end

        // Saturation: a taken beq sits in D every cycle after the first edge
        reset = 1'b1; stall = 1'b0; instr_f = NOP; judge = 1'b0; rs_d = 32'd0;
        @(posedge clk);
        #1;
        chk("sat_reset_br", -1, {28'd0, s_br_cnt}, 32'd0);
        reset = 1'b0; instr_f = BEQ3; judge = 1'b1;
        for (int k = 0; k < 20; k++) begin
            logic [31:0] exp4;
            @(posedge clk);
            #1;
            exp4 = (k < 15) ? k : 15;
            $display("sat %0d br4=%0d tk4=%0d br16=%0d", k, s_br_cnt, s_taken_cnt, br_cnt);
            chk("sat_br4",  k, {28'd0, s_br_cnt},    exp4);
            chk("sat_tk4",  k, {28'd0, s_taken_cnt}, exp4);
            chk("sat_br16", k, {16'd0, br_cnt},      k);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
